// File: rtl/tetra_lut_interp_seq.sv
// rtl/tetra_lut_interp_seq.sv - sequential tetrahedral 3D-LUT interpolator over a single-port LUT SRAM
// Optional TETRA_ROUND_EN: round accumulations back to node scale on out_data.
module tetra_lut_interp_seq #(
  parameter int IN_W      = 8,
  parameter int OFFSET    = 16,
  parameter int IDX_SHIFT = 4,
  parameter int FRAC_W    = 3,
  parameter int GRID      = 15,
  parameter int CH        = 4,
  parameter int CW        = 8,
  parameter int ADDR_W    = 12,
  parameter int OUT_W     = CW + FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_x,
  input  logic [IN_W-1:0]       in_y,
  input  logic [IN_W-1:0]       in_z,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [CH*CW-1:0]      mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data
);

  localparam int WW = FRAC_W + 1;
  localparam logic [WW-1:0]     S     = WW'(1 << FRAC_W);
  localparam logic [ADDR_W-1:0] STR_X = ADDR_W'(GRID * GRID);
  localparam logic [ADDR_W-1:0] STR_Y = ADDR_W'(GRID);
  localparam logic [ADDR_W-1:0] STR_Z = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                k_q, k_d;
  logic [ADDR_W-1:0]         addr_q [4];
  logic [ADDR_W-1:0]         addr_d [4];
  logic [WW-1:0]             w_q [4];
  logic [WW-1:0]             w_d [4];
  logic signed [OUT_W-1:0]   acc_q [CH];
  logic signed [OUT_W-1:0]   acc_d [CH];

  logic [IN_W-1:0]           samp [3];
  logic [IN_W-1:0]           n [3];
  logic [IN_W-1:0]           idx [3];
  logic [WW-1:0]             lf [3];
  logic [ADDR_W-1:0]         base, off1, off2;
  logic [WW-1:0]             mx, md, mn;
  logic [1:0]                widx;
  logic                      acc_en;
  logic signed [OUT_W:0]     w_ext;
  logic signed [OUT_W:0]     lane_ext [CH];
  logic signed [OUT_W:0]     prod [CH];

  assign samp[0] = in_x;
  assign samp[1] = in_y;
  assign samp[2] = in_z;

  // Past the last cell the index pins to the final cell with full weight on the upper node.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      n[a]   = (samp[a] < IN_W'(OFFSET)) ? '0 : samp[a] - IN_W'(OFFSET);
      idx[a] = n[a] >> IDX_SHIFT;
      lf[a]  = {1'b0, n[a][IDX_SHIFT-1 -: FRAC_W]};
      if (idx[a] >= IN_W'(GRID - 1)) begin
        idx[a] = IN_W'(GRID - 2);
        lf[a]  = S;
      end
    end
    base = ADDR_W'(idx[0]) * STR_X + ADDR_W'(idx[1]) * STR_Y + ADDR_W'(idx[2]);
  end

  // off1/off2 are the strides walked from P000 towards P111; mx/md/mn follow the same axis order.
  always_comb begin
    off1 = STR_Y; off2 = STR_X; mx = lf[1]; md = lf[0]; mn = lf[2];
    if (lf[0] > lf[1]) begin
      if (lf[1] > lf[2]) begin
        off1 = STR_X; off2 = STR_Y; mx = lf[0]; md = lf[1]; mn = lf[2];
      end else if (lf[0] > lf[2]) begin
        off1 = STR_X; off2 = STR_Z; mx = lf[0]; md = lf[2]; mn = lf[1];
      end else begin
        off1 = STR_Z; off2 = STR_X; mx = lf[2]; md = lf[0]; mn = lf[1];
      end
    end else begin
      if (lf[2] > lf[1]) begin
        off1 = STR_Z; off2 = STR_Y; mx = lf[2]; md = lf[1]; mn = lf[0];
      end else if (lf[2] > lf[0]) begin
        off1 = STR_Y; off2 = STR_Z; mx = lf[1]; md = lf[2]; mn = lf[0];
      end
    end
  end

  // Read data lags the strobe by one cycle, so the weight index trails k by one.
  assign acc_en = (state_q == FETCH && k_q != 2'd0) || state_q == DRAIN;
  assign widx   = (state_q == DRAIN) ? 2'd3 : k_q - 2'd1;
  assign w_ext  = {{(OUT_W + 1 - WW){1'b0}}, w_q[widx]};

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      lane_ext[c] = {{(OUT_W + 1 - CW){mem_rdata[c*CW + CW - 1]}}, mem_rdata[c*CW +: CW]};
      prod[c]     = lane_ext[c] * w_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    w_d     = w_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d   = FETCH;
        k_d       = 2'd0;
        addr_d[0] = base;
        addr_d[1] = base + off1;
        addr_d[2] = base + off1 + off2;
        addr_d[3] = base + STR_X + STR_Y + STR_Z;
        w_d[0]    = S - mx;
        w_d[1]    = mx - md;
        w_d[2]    = md - mn;
        w_d[3]    = mn;
        for (int c = 0; c < CH; c++) acc_d[c] = '0;
      end
      FETCH: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (acc_en) begin
      for (int c = 0; c < CH; c++) acc_d[c] = acc_q[c] + prod[c][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        w_q[i]    <= '0;
      end
      for (int c = 0; c < CH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign mem_en    = (state_q == FETCH);
  assign mem_addr  = mem_en ? addr_q[k_q] : '0;
  assign out_valid = (state_q == OUT);

`ifdef TETRA_ROUND_EN
  localparam logic signed [OUT_W:0] RND_HALF = (OUT_W + 1)'(1 << (FRAC_W - 1));
  logic signed [OUT_W:0] rnd [CH];

  always_comb begin
    out_data = '0;
    for (int c = 0; c < CH; c++) begin
      rnd[c] = {acc_q[c][OUT_W-1], acc_q[c]} + RND_HALF;
      out_data[c*OUT_W +: OUT_W] = OUT_W'(rnd[c] >>> FRAC_W);
    end
  end
`else
  always_comb begin
    out_data = '0;
    for (int c = 0; c < CH; c++) out_data[c*OUT_W +: OUT_W] = acc_q[c];
  end
`endif

endmodule

// File: tb/tb_tetra_lut_interp_seq.sv
// tb/tb_tetra_lut_interp_seq.sv - randomized self-checking bench for tetra_lut_interp_seq
// Honours TETRA_ROUND_EN the same way as the design build.
module tb_tetra_lut_interp_seq;

  localparam int CH = 4, CW = 8, OUT_W = 11, AW = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_x, in_y, in_z;
  logic               mem_en;
  logic [AW-1:0]      mem_addr;
  logic [CH*CW-1:0]   mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [CH*OUT_W-1:0] out_data;

  logic [CH*CW-1:0]   mem [4096];
  int                 pass_cnt = 0;
  int                 total_cnt = 0;

  tetra_lut_interp_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference: walk from P000 to P111 stepping axes in descending-fraction order.
  task automatic model_txn(input int x, input int y, input int z, output int ao[4], output int wo[4]);
    int s[3], ii[3], l[3], d[3], o[3], cs, nv;
    int ord [6][3];
    ord = '{'{0,1,2}, '{0,2,1}, '{2,0,1}, '{2,1,0}, '{1,2,0}, '{1,0,2}};
    s = '{x, y, z};
    for (int a = 0; a < 3; a++) begin
      nv = (s[a] >= 16) ? s[a] - 16 : 0;
      ii[a] = nv / 16;
      l[a] = (nv % 16) / 2;
      if (ii[a] >= 14) begin ii[a] = 13; l[a] = 8; end
    end
    if (l[0] > l[1]) cs = (l[1] > l[2]) ? 0 : (l[0] > l[2]) ? 1 : 2;
    else             cs = (l[2] > l[1]) ? 3 : (l[2] > l[0]) ? 4 : 5;
    o = ord[cs];
    d = '{0, 0, 0};
    ao[0] = ii[0]*225 + ii[1]*15 + ii[2];
    for (int k = 1; k < 4; k++) begin
      d[o[k-1]] = 1;
      ao[k] = (ii[0]+d[0])*225 + (ii[1]+d[1])*15 + (ii[2]+d[2]);
    end
    wo[0] = 8 - l[o[0]];
    wo[1] = l[o[0]] - l[o[1]];
    wo[2] = l[o[1]] - l[o[2]];
    wo[3] = l[o[2]];
  endtask

  function automatic logic [CH*OUT_W-1:0] model_out(input int ao[4], input int wo[4]);
    logic [CH*OUT_W-1:0] r;
    logic [CH*CW-1:0] wd;
    int acc, lv, q;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        wd = mem[ao[k]];
        lv = $signed(wd[c*CW +: CW]);
        acc += lv * wo[k];
      end
`ifdef TETRA_ROUND_EN
      q = acc + 4;
      q = (q >= 0) ? q / 8 : -((-q + 7) / 8);
`else
      q = acc;
`endif
      r[c*OUT_W +: OUT_W] = q[OUT_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [CH*CW-1:0] lanes4(input int a, input int b, input int c, input int d);
    int v[4];
    logic [CH*CW-1:0] r;
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) r[i*CW +: CW] = v[i][CW-1:0];
    return r;
  endfunction

  function automatic logic [CH*OUT_W-1:0] pack4(input int a, input int b, input int c, input int d);
    int v[4];
    logic [CH*OUT_W-1:0] r;
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) r[i*OUT_W +: OUT_W] = v[i][OUT_W-1:0];
    return r;
  endfunction

  // SRAM: capture the strobe mid-cycle, present data just after the next edge.
  logic          en_s;
  logic [AW-1:0] a_s;
  always @(negedge clk) begin
    en_s = mem_en;
    a_s  = mem_addr;
    @(posedge clk);
    #1 mem_rdata = en_s ? mem[a_s] : $urandom;
  end

  // Cycle-level expectation: ph counts cycles since the accepting edge.
  bit known = 0, busy = 0, clean = 0;
  int ph = 0;
  int ea[4], ew[4];
  logic [CH*OUT_W-1:0] eo;
  always @(negedge clk) begin
    if (known && !busy) begin
      chk("idle_in_ready", in_ready, !rst);
      chk("idle_mem_en", mem_en, 0);
      chk("idle_out_valid", out_valid, 0);
      if (clean) begin
        chk("reset_out_data", out_data, 0);
        chk("reset_mem_addr", mem_addr, 0);
      end
    end else if (known) begin
      chk("busy_in_ready", in_ready, 0);
      chk("mem_en", mem_en, ph >= 1 && ph <= 4);
      if (ph >= 1 && ph <= 4) chk("mem_addr", mem_addr, ea[ph-1]);
      chk("out_valid", out_valid, ph >= 6);
      if (ph >= 6) chk("out_data", out_data, eo);
    end else if (rst) begin
      chk("rst_in_ready", in_ready, 0);
    end
    if (rst) begin
      known = 1; busy = 0; clean = 1;
    end else if (known) begin
      if (!busy) begin
        if (in_valid) begin
          model_txn(in_x, in_y, in_z, ea, ew);
          eo = model_out(ea, ew);
          busy = 1; ph = 1; clean = 0;
        end
      end else if (ph >= 6) begin
        if (out_ready) busy = 0;
      end else begin
        ph++;
      end
    end
  end

  task automatic send(input int x, input int y, input int z, input bit keep);
    int n = 0;
    in_x = 8'(x); in_y = 8'(y); in_z = 8'(z);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit rnd_ready);
    int n = 0;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(out_valid && out_ready) && n < 200) begin
      @(posedge clk); #1; n++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("out_handshake", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic int pick();
    int edges[7];
    edges = '{0, 15, 16, 17, 239, 240, 255};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 6)];
    return $urandom_range(0, 255);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ao[4], wo[4];
    int nx, ny, nz, cx, cy, cz;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;

    // Model pins from hand-worked cases.
    mem[0] = lanes4(-3, 5, 127, -128);
    model_txn(16, 16, 16, ao, wo);
    chk("pin1_addr", {ao[0][15:0], ao[1][15:0], ao[2][15:0], ao[3][15:0]}, {16'd0, 16'd15, 16'd240, 16'd241});
    chk("pin1_w", {wo[0][7:0], wo[1][7:0], wo[2][7:0], wo[3][7:0]}, {8'd8, 8'd0, 8'd0, 8'd0});
`ifdef TETRA_ROUND_EN
    chk("pin1_out", model_out(ao, wo), pack4(-3, 5, 127, -128));
`else
    chk("pin1_out", model_out(ao, wo), pack4(-24, 40, 1016, -1024));
`endif
    foreach (ao[k]) mem[465] = lanes4(10, 10, 10, 10);
    mem[480] = lanes4(10, 10, 10, 10);
    mem[705] = lanes4(10, 10, 10, 10);
    mem[706] = lanes4(10, 10, 10, 10);
    model_txn(54, 42, 20, ao, wo);
    chk("pin2_addr", {ao[0][15:0], ao[1][15:0], ao[2][15:0], ao[3][15:0]}, {16'd465, 16'd480, 16'd705, 16'd706});
    chk("pin2_w", {wo[0][7:0], wo[1][7:0], wo[2][7:0], wo[3][7:0]}, {8'd3, 8'd2, 8'd1, 8'd2});
`ifdef TETRA_ROUND_EN
    chk("pin2_out", model_out(ao, wo), pack4(10, 10, 10, 10));
`else
    chk("pin2_out", model_out(ao, wo), pack4(80, 80, 80, 80));
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(16, 16, 16, 0); wait_out(0);
    send(54, 42, 20, 0); wait_out(0);
    send(5, 255, 16, 0); wait_out(0);

    // Output backpressure: hold out_ready low for 3 cycles once out_valid rises.
    send(pick(), pick(), pick(), 0);
    for (int n = 0; n < 50 && !out_valid; n++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    wait_out(0);

    // Reset pulsed in cycle T+3 of a transaction.
    send(pick(), pick(), pick(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end

    // Back-to-back: next triple already valid while the previous one drains.
    cx = pick(); cy = pick(); cz = pick();
    for (int t = 0; t < 6; t++) begin
      send(cx, cy, cz, 1);
      nx = pick(); ny = pick(); nz = pick();
      in_x = 8'(nx); in_y = 8'(ny); in_z = 8'(nz);
      wait_out(0);
      cx = nx; cy = ny; cz = nz;
    end
    send(cx, cy, cz, 0);
    wait_out(0);

    // Randomized traffic with random downstream readiness and idle gaps.
    for (int t = 0; t < 50; t++) begin
      for (int j = 0; j < 8; j++) mem[$urandom_range(0, 3374)] = $urandom;
      send(pick(), pick(), pick(), 0);
      wait_out(1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
